booth_mult_arbiter: RTL

- Shares one 8x8 signed sequential Booth multiplier core among NUM_REQ requesters.
- Arbitration is round-robin.
- Latches the winner's operands, then holds the core's level-sensitive start until the core pulses done.
- Captures the 16-bit product and returns it to the winner with a one-cycle valid strobe.
- Sits between client blocks and the single shared multiplier instance.

---
 rtl/booth_mult_arbiter_if.sv | 31 +++
 rtl/booth_mult_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter_if.sv
// Client/core bundle for booth_mult_arbiter: request side toward the clients and
// the start/done handshake toward the single shared Booth core.
interface booth_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][7:0] req_a;
  logic [NUM_REQ-1:0][7:0] req_b;
  logic [NUM_REQ-1:0]      ack;
  logic [NUM_REQ-1:0]      res_valid;
  logic [15:0]             res_product;
  logic                    busy;
  logic                    mul_start;
  logic [7:0]              mul_a;
  logic [7:0]              mul_b;
  logic                    mul_done;
  logic [15:0]             mul_product;
  logic                    err_timeout;

  // Clients plus core model side.
  modport master (
    output req, req_a, req_b, mul_done, mul_product,
    input  ack, res_valid, res_product, busy, mul_start, mul_a, mul_b, err_timeout
  );

  // Arbiter side.
  modport slave (
    input  req, req_a, req_b, mul_done, mul_product,
    output ack, res_valid, res_product, busy, mul_start, mul_a, mul_b, err_timeout
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 signed Booth core among NUM_REQ clients.
// Optional RUN watchdog enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PTR_W       = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_mult_arbiter_if.slave bus
);

  if (PTR_W < $clog2(NUM_REQ)) begin : g_bad_ptr_w
    $error("PTR_W too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] res_valid_q;
  logic [15:0]        res_product_q;
  logic               busy_q;
  logic               mul_start_q;
  logic [7:0]         mul_a_q;
  logic [7:0]         mul_b_q;

  logic               win_vld_d;
  logic [PTR_W-1:0]   win_idx_d;
  logic [PTR_W-1:0]   scan_idx;

  // Scan downward so the candidate nearest rr_q is the last (winning) assignment.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    scan_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = PTR_W'((int'(rr_q) + i) % NUM_REQ);
      if (bus.req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      res_valid_q   <= '0;
      res_product_q <= '0;
      busy_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      ack_q       <= '0;
      res_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            mul_a_q            <= bus.req_a[win_idx_d];
            mul_b_q            <= bus.req_b[win_idx_d];
            mul_start_q        <= 1'b1;
            ack_q[win_idx_d]   <= 1'b1;
            grant_q            <= win_idx_d;
            busy_q             <= 1'b1;
            state_q            <= RUN;
`ifdef BOOTH_ARB_TIMEOUT_EN
            cnt_q              <= '0;
`endif
          end
        end
        RUN: begin
          // Start must fall on the done edge or the core reruns the operation.
          if (bus.mul_done) begin
            res_product_q        <= bus.mul_product;
            mul_start_q          <= 1'b0;
            res_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_q                <= 1'b1;
            res_product_q        <= '0;
            mul_start_q          <= 1'b0;
            res_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          rr_q    <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign bus.busy        = busy_q;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule
